// File: rtl/lzd_seq_pkg.sv
// Shared types and constants for the multi-cycle leading-zero normalizer.
package lzd_seq_pkg;

  localparam int unsigned LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } lzd_seq_state_t;

endpackage

// File: rtl/leading_zeros_detector.sv
// Combinational 32-bit leading-zero counter; zeros is don't-care when all_zeros is set.
module leading_zeros_detector
  import lzd_seq_pkg::*;
(
  input  logic [LANE_W-1:0] data,
  output logic [4:0]        zeros,
  output logic              all_zeros
);

  // Scan LSB to MSB so the highest set bit wins.
  always_comb begin
    zeros     = 5'd0;
    all_zeros = 1'b1;
    for (int i = 0; i < LANE_W; i++) begin
      if (data[i]) begin
        zeros     = 5'(LANE_W - 1 - i);
        all_zeros = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lzd_normalize_sequencer.sv
// Wide-mantissa normalizer: scans one 32-bit word per cycle through a shared LZD,
// then shifts the mantissa and adjusts the exponent with saturation.
module lzd_normalize_sequencer
  import lzd_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned EXP_W = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_mantissa,
  input  logic [EXP_W-1:0]                  in_exponent,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_mantissa,
  output logic [EXP_W-1:0]                  out_exponent,
  output logic [$clog2(WIDTH+1)-1:0]        out_lz,
  output logic                              out_zero,
  output logic                              out_underflow
);

  localparam int unsigned NW    = WIDTH / LANE_W;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;

  lzd_seq_state_t   state_q;
  logic [WIDTH-1:0] mant_q;
  logic [EXP_W-1:0] exp_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] lz_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_mantissa_q;
  logic [EXP_W-1:0] out_exponent_q;
  logic [CNT_W-1:0] out_lz_q;
  logic             out_zero_q;
  logic             out_underflow_q;

  logic [LANE_W-1:0] word_c;
  logic [4:0]        zeros_c;
  logic              all_zeros_c;
  logic [EXP_W:0]    exp_diff_c;
  logic              uflow_c;
  logic [EXP_W-1:0]  exp_sat_c;

  // Word currently under inspection, selected by the scan index.
  always_comb begin
    word_c = '0;
    for (int w = 0; w < NW; w++) begin
      if (idx_q == IDX_W'(w)) begin
        word_c = mant_q[w*LANE_W +: LANE_W];
      end
    end
  end

  leading_zeros_detector u_lzd (
    .data      (word_c),
    .zeros     (zeros_c),
    .all_zeros (all_zeros_c)
  );

  // One extra bit of headroom; the result can only move downward, so a 10 top pair means underflow.
  always_comb begin
    exp_diff_c = {exp_q[EXP_W-1], exp_q} - (EXP_W+1)'(lz_q);
    uflow_c    = exp_diff_c[EXP_W] & ~exp_diff_c[EXP_W-1];
    exp_sat_c  = uflow_c ? {1'b1, {(EXP_W-1){1'b0}}} : exp_diff_c[EXP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mant_q          <= '0;
      exp_q           <= '0;
      idx_q           <= '0;
      acc_q           <= '0;
      lz_q            <= '0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_mantissa_q  <= '0;
      out_exponent_q  <= '0;
      out_lz_q        <= '0;
      out_zero_q      <= 1'b0;
      out_underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mant_q     <= in_mantissa;
            exp_q      <= in_exponent;
            idx_q      <= IDX_W'(NW - 1);
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (!all_zeros_c) begin
            lz_q    <= acc_q + CNT_W'(zeros_c);
            state_q <= SHIFT;
          end else if (idx_q == '0) begin
            out_mantissa_q  <= '0;
            out_exponent_q  <= exp_q;
            out_lz_q        <= CNT_W'(WIDTH);
            out_zero_q      <= 1'b1;
            out_underflow_q <= 1'b0;
            state_q         <= DONE;
          end else begin
            acc_q <= acc_q + CNT_W'(LANE_W);
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        SHIFT: begin
          out_mantissa_q  <= mant_q << lz_q;
          out_exponent_q  <= exp_sat_c;
          out_lz_q        <= lz_q;
          out_zero_q      <= 1'b0;
          out_underflow_q <= uflow_c;
          state_q         <= DONE;
        end
        DONE: begin
          // Results were written on entry; valid rises one cycle later and holds until taken.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_mantissa  = out_mantissa_q;
  assign out_exponent  = out_exponent_q;
  assign out_lz        = out_lz_q;
  assign out_zero      = out_zero_q;
  assign out_underflow = out_underflow_q;

endmodule
